osc_waveshaper: RTL and testbench

//  Per-slot waveform stage directly downstream of the NCO phase accumulator. Each cycle it takes the
//  11-bit phase of the current {vx,ox} slot and converts it to a signed 16-bit sample.

---
 rtl/osc_waveshaper.sv | 173 +++++++++++++++++
 tb/tb_osc_waveshaper.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_waveshaper.sv
// osc_waveshaper: turns the 11-bit NCO phase of each {vx,ox} slot into a signed
// 16-bit sample (saw / pulse / triangle / parabolic sine / LFSR noise).
// Three register stages: S1 capture + config lookup, S2 shape, S3 output.
module osc_waveshaper #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2
) (
    input  logic               sCLK_XVXOSC,
    input  logic               reset_reg_N,
    input  logic               in_valid,
    input  logic [10:0]        phase_acc,
    input  logic [V_WIDTH-1:0] vx,
    input  logic [O_WIDTH-1:0] ox,
    input  logic               cfg_we,
    input  logic [O_WIDTH-1:0] cfg_osc,
    input  logic [2:0]         cfg_wave,
    input  logic [6:0]         cfg_pw,
    output logic               out_valid,
    output logic [15:0]        out_sample,
    output logic [V_WIDTH-1:0] out_vx,
    output logic [O_WIDTH-1:0] out_ox
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // per-oscillator configuration table
    logic [2:0]         cfg_wave_q [V_OSC];
    logic [6:0]         cfg_pw_q   [V_OSC];

    // S1 registers
    logic               s1_valid_q;
    logic [10:0]        s1_phase_q;
    logic [V_WIDTH-1:0] s1_vx_q;
    logic [O_WIDTH-1:0] s1_ox_q;
    logic [2:0]         s1_wave_q;
    logic [6:0]         s1_pw_q;
    logic [15:0]        s1_noise_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;

    // S2 registers
    logic               s2_valid_q;
    logic [15:0]        s2_sample_q;
    logic [V_WIDTH-1:0] s2_vx_q;
    logic [O_WIDTH-1:0] s2_ox_q;

    // S3 / output registers
    logic               out_valid_q;
    logic [15:0]        out_sample_q;
    logic [V_WIDTH-1:0] out_vx_q;
    logic [O_WIDTH-1:0] out_ox_q;

    // shape datapath
    logic [15:0]        shape_d;
    logic [15:0]        saw_s;
    logic [15:0]        pulse_s;
    logic [9:0]         tri_t;
    logic [15:0]        tri_s;
    logic [9:0]         sine_x;
    logic [19:0]        sine_y;
    logic [15:0]        sine_m;
    logic [15:0]        sine_s;
    logic               unused_bits;

    // Fibonacci LFSR step, taps 16,14,13,11; the seed is non-zero so it never locks up
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // config writes land on the edge, so a same-cycle lookup still sees the old entry
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < V_OSC; i++) begin
                cfg_wave_q[i] <= 3'd0;
                cfg_pw_q[i]   <= 7'd64;
            end
        end else if (cfg_we) begin
            cfg_wave_q[cfg_osc] <= cfg_wave;
            cfg_pw_q[cfg_osc]   <= cfg_pw;
        end
    end

    // S1: capture the slot, look up its config and snapshot the noise source
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
            s1_vx_q    <= '0;
            s1_ox_q    <= '0;
            s1_wave_q  <= 3'd0;
            s1_pw_q    <= 7'd0;
            s1_noise_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            s1_valid_q <= in_valid;
            s1_phase_q <= phase_acc;
            s1_vx_q    <= vx;
            s1_ox_q    <= ox;
            s1_wave_q  <= cfg_wave_q[ox];
            s1_pw_q    <= cfg_pw_q[ox];
            s1_noise_q <= lfsr_q;
            if (in_valid) begin
                lfsr_q <= lfsr_d;
            end
        end
    end

    // all shapes are derived in parallel from the S1 phase
    assign saw_s   = {s1_phase_q, 5'b0} ^ 16'h8000;
    assign pulse_s = (s1_phase_q[10:4] < s1_pw_q) ? 16'h7FFF : 16'h8001;
    assign tri_t   = s1_phase_q[9:0] ^ {10{s1_phase_q[10]}};
    assign tri_s   = {tri_t, 6'b0} ^ 16'h8000;
    assign sine_x  = s1_phase_q[9:0];
    assign sine_y  = {10'd0, sine_x} * {10'd0, 10'd1023 - sine_x};
    assign sine_m  = sine_y[18:3];
    assign sine_s  = s1_phase_q[10] ? (16'd0 - sine_m) : sine_m;

    // peak of x*(1023-x) fits in 18 bits, so the top bit and the shifted-out bits are dropped
    assign unused_bits = ^{sine_y[19], sine_y[2:0], VOICES[0]};

    // pick the configured shape; undefined codes are silent
    always_comb begin
        shape_d = 16'd0;
        case (s1_wave_q)
            3'd0:    shape_d = saw_s;
            3'd1:    shape_d = pulse_s;
            3'd2:    shape_d = tri_s;
            3'd3:    shape_d = sine_s;
            3'd4:    shape_d = s1_noise_q;
            default: shape_d = 16'd0;
        endcase
    end

    // S2: register the selected sample; tags only follow valid slots
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            s2_valid_q  <= 1'b0;
            s2_sample_q <= '0;
            s2_vx_q     <= '0;
            s2_ox_q     <= '0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_sample_q <= shape_d;
            if (s1_valid_q) begin
                s2_vx_q <= s1_vx_q;
                s2_ox_q <= s1_ox_q;
            end
        end
    end

    // S3: output register; bubbles give a zero sample while tags hold
    always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_vx_q     <= '0;
            out_ox_q     <= '0;
        end else begin
            out_valid_q  <= s2_valid_q;
            out_sample_q <= s2_valid_q ? s2_sample_q : 16'd0;
            if (s2_valid_q) begin
                out_vx_q <= s2_vx_q;
                out_ox_q <= s2_ox_q;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign out_vx     = out_vx_q;
    assign out_ox     = out_ox_q;

endmodule

// File: tb/tb_osc_waveshaper.sv
// Self-checking bench for osc_waveshaper: directed scenarios plus a random
// back-to-back stream, all compared against an arithmetic waveform model.
module tb_osc_waveshaper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] phase_acc;
    logic [2:0]  vx;
    logic [1:0]  ox;
    logic        cfg_we;
    logic [1:0]  cfg_osc;
    logic [2:0]  cfg_wave;
    logic [6:0]  cfg_pw;
    logic        out_valid;
    logic [15:0] out_sample;
    logic [2:0]  out_vx;
    logic [1:0]  out_ox;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osc_waveshaper #(.VOICES(8), .V_OSC(4), .V_WIDTH(3), .O_WIDTH(2)) dut (
        .sCLK_XVXOSC (clk),
        .reset_reg_N (rst_n),
        .in_valid    (in_valid),
        .phase_acc   (phase_acc),
        .vx          (vx),
        .ox          (ox),
        .cfg_we      (cfg_we),
        .cfg_osc     (cfg_osc),
        .cfg_wave    (cfg_wave),
        .cfg_pw      (cfg_pw),
        .out_valid   (out_valid),
        .out_sample  (out_sample),
        .out_vx      (out_vx),
        .out_ox      (out_ox)
    );

    typedef struct {
        bit        v;
        bit [10:0] ph;
        bit [2:0]  vx;
        bit [1:0]  ox;
        bit        we;
        bit [1:0]  wosc;
        bit [2:0]  wave;
        bit [6:0]  pw;
    } stim_t;

    stim_t       stim_q[$];
    logic        exp_v[$];
    logic [15:0] exp_s[$];
    logic [2:0]  exp_vx[$];
    logic [1:0]  exp_ox[$];
    logic        obs_v[$];
    logic [15:0] obs_s[$];
    logic [2:0]  obs_vx[$];
    logic [1:0]  obs_ox[$];

    // reference model state
    int        m_wave[4];
    int        m_pw[4];
    bit [15:0] m_lfsr;
    bit [2:0]  m_vx;
    bit [1:0]  m_ox;

    function automatic int ref_shape(int wave, int pw, int p, int noise);
        int t;
        int x;
        int m;
        case (wave)
            0: return p * 32 - 32768;
            1: return ((p / 16) < pw) ? 32767 : -32767;
            2: begin
                t = (p < 1024) ? p : 2047 - p;
                return t * 64 - 32768;
            end
            3: begin
                x = p % 1024;
                m = (x * (1023 - x)) / 8;
                return (p >= 1024) ? -m : m;
            end
            4: return (noise >= 32768) ? noise - 65536 : noise;
            default: return 0;
        endcase
    endfunction

    function automatic bit [15:0] lfsr_step(bit [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_wave[i] = 0;
            m_pw[i]   = 64;
        end
        m_lfsr = 16'hACE1;
        m_vx   = 3'd0;
        m_ox   = 2'd0;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        phase_acc = 11'($urandom);
        vx        = 3'($urandom);
        ox        = 2'($urandom);
        cfg_we    = 1'b0;
        cfg_osc   = 2'd0;
        cfg_wave  = 3'd0;
        cfg_pw    = 7'd0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // drive stim_q one item per cycle; record what the model predicts and what comes out 3 edges later
    task automatic run_stim();
        int    n;
        int    e;
        stim_t st;
        n = stim_q.size();
        exp_v.delete(); exp_s.delete(); exp_vx.delete(); exp_ox.delete();
        obs_v.delete(); obs_s.delete(); obs_vx.delete(); obs_ox.delete();
        for (int s = 0; s < n + 3; s++) begin
            @(negedge clk);
            if (s >= 3) begin
                obs_v.push_back(out_valid);
                obs_s.push_back(out_sample);
                obs_vx.push_back(out_vx);
                obs_ox.push_back(out_ox);
            end
            if (s < n) begin
                st = stim_q[s];
                in_valid  = st.v;
                phase_acc = st.ph;
                vx        = st.vx;
                ox        = st.ox;
                cfg_we    = st.we;
                cfg_osc   = st.wosc;
                cfg_wave  = st.wave;
                cfg_pw    = st.pw;
                if (st.v) begin
                    e = ref_shape(m_wave[st.ox], m_pw[st.ox], int'(st.ph), int'(m_lfsr));
                    m_lfsr = lfsr_step(m_lfsr);
                    m_vx   = st.vx;
                    m_ox   = st.ox;
                    exp_v.push_back(1'b1);
                    exp_s.push_back(16'(e));
                end else begin
                    exp_v.push_back(1'b0);
                    exp_s.push_back(16'd0);
                end
                exp_vx.push_back(m_vx);
                exp_ox.push_back(m_ox);
                if (st.we) begin
                    m_wave[st.wosc] = int'(st.wave);
                    m_pw[st.wosc]   = int'(st.pw);
                end
            end else begin
                drive_idle();
            end
        end
        stim_q.delete();
    endtask

    function automatic stim_t mk(bit v, int ph, int vxi, int oxi);
        stim_t st;
        st.v = v; st.ph = 11'(ph); st.vx = 3'(vxi); st.ox = 2'(oxi);
        st.we = 1'b0; st.wosc = 2'd0; st.wave = 3'd0; st.pw = 7'd0;
        return st;
    endfunction

    function automatic stim_t mk_cfg(int osc, int wave, int pw);
        stim_t st;
        st = mk(1'b0, 0, 0, 0);
        st.we = 1'b1; st.wosc = 2'(osc); st.wave = 3'(wave); st.pw = 7'(pw);
        return st;
    endfunction

    task automatic test_reset();
        drive_idle();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        phase_acc = 11'd0;
        vx        = 3'd5;
        ox        = 2'd0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_sample !== 16'd0 || out_vx !== 3'd0 || out_ox !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=0 s=0000 vx=0 ox=0",
                         k, out_valid, out_sample, out_vx, out_ox);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL reset_latency[%0d]: got out_valid=%0b, want %0b", k, out_valid, (k == 3));
            end
        end
        checks++;
        if (out_sample !== 16'h8000 || out_vx !== 3'd5 || out_ox !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_sample: got s=%h vx=%0d ox=%0d, want s=8000 vx=5 ox=0",
                     out_sample, out_vx, out_ox);
        end
        $display("reset: first sample %h vx=%0d ox=%0d", out_sample, out_vx, out_ox);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_lfsr = lfsr_step(m_lfsr);
        m_vx = 3'd5;
        m_ox = 2'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_midstream_reset();
        drive_idle();
        in_valid  = 1'b1;
        phase_acc = 11'd1024;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill: got out_valid=%0b, want 1", out_valid);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 16'd0 || out_vx !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: got v=%0b s=%h vx=%0d, want v=0 s=0000 vx=0", out_valid, out_sample, out_vx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_discard[%0d]: got out_valid=%0b, want 0", k, out_valid);
            end
        end
        $display("midstream reset: pipeline flushed");
    endtask

    task automatic test_saw();
        logic [15:0] want[3];
        want[0] = 16'h8000; want[1] = 16'h0000; want[2] = 16'h7FE0;
        stim_q.push_back(mk_cfg(0, 0, 64));
        stim_q.push_back(mk(1'b1, 0,    1, 0));
        stim_q.push_back(mk(1'b1, 1024, 2, 0));
        stim_q.push_back(mk(1'b1, 2047, 3, 0));
        run_stim();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_s[i+1] !== want[i] || obs_vx[i+1] !== 3'(i + 1) || obs_ox[i+1] !== 2'd0 || obs_v[i+1] !== 1'b1) begin
                errors++;
                $display("FAIL saw_const[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=1 s=%h vx=%0d ox=0",
                         i, obs_v[i+1], obs_s[i+1], obs_vx[i+1], obs_ox[i+1], want[i], i + 1);
            end
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("saw[%0d] v=%0b s=%0d vx=%0d ox=%0d", i, obs_v[i], $signed(obs_s[i]), obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL saw[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    task automatic test_pulse();
        stim_q.push_back(mk_cfg(1, 1, 64));
        stim_q.push_back(mk(1'b1, 1023, 4, 1));
        stim_q.push_back(mk(1'b1, 1024, 4, 1));
        stim_q.push_back(mk_cfg(1, 1, 0));
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(1'b1, int'($urandom_range(0, 2047)), 6, 1));
        run_stim();
        checks++;
        if (obs_s[1] !== 16'h7FFF || obs_s[2] !== 16'h8001) begin
            errors++;
            $display("FAIL pulse_const: got %h %h, want 7fff 8001", obs_s[1], obs_s[2]);
        end
        for (int i = 4; i < 8; i++) begin
            checks++;
            if (obs_s[i] !== 16'h8001) begin
                errors++;
                $display("FAIL pulse_pw0[%0d]: got %h, want 8001", i, obs_s[i]);
            end
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("pulse[%0d] v=%0b s=%0d vx=%0d ox=%0d", i, obs_v[i], $signed(obs_s[i]), obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL pulse[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    task automatic test_sine();
        logic [15:0] want[4];
        want[0] = 16'h7FC0; want[1] = 16'h8040; want[2] = 16'h0000; want[3] = 16'h0000;
        stim_q.push_back(mk_cfg(2, 3, 10));
        stim_q.push_back(mk(1'b1, 512,  7, 2));
        stim_q.push_back(mk(1'b1, 1536, 7, 2));
        stim_q.push_back(mk(1'b1, 0,    7, 2));
        stim_q.push_back(mk(1'b1, 1024, 7, 2));
        for (int i = 0; i < 6; i++) stim_q.push_back(mk(1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)), 2));
        run_stim();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_s[i+1] !== want[i]) begin
                errors++;
                $display("FAIL sine_const[%0d]: got %h, want %h", i, obs_s[i+1], want[i]);
            end
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("sine[%0d] v=%0b s=%0d vx=%0d ox=%0d", i, obs_v[i], $signed(obs_s[i]), obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL sine[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    task automatic test_noise();
        do_reset();
        stim_q.push_back(mk_cfg(3, 4, 0));
        stim_q.push_back(mk(1'b1, 5, 0, 3));
        stim_q.push_back(mk(1'b1, 6, 1, 3));
        stim_q.push_back(mk(1'b0, 7, 2, 3));
        stim_q.push_back(mk(1'b1, 8, 3, 3));
        stim_q.push_back(mk(1'b1, 9, 4, 3));
        run_stim();
        checks++;
        if (obs_s[1] !== 16'hACE1 || obs_s[2] !== 16'h59C3) begin
            errors++;
            $display("FAIL noise_seed: got %h %h, want ace1 59c3", obs_s[1], obs_s[2]);
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("noise[%0d] v=%0b s=%h vx=%0d ox=%0d", i, obs_v[i], obs_s[i], obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL noise[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    task automatic test_cfg_collision();
        stim_t st;
        stim_q.push_back(mk_cfg(2, 3, 0));
        st = mk(1'b1, 512, 2, 2);
        st.we = 1'b1; st.wosc = 2'd2; st.wave = 3'd2; st.pw = 7'd0;
        stim_q.push_back(st);
        stim_q.push_back(mk(1'b1, 512, 3, 2));
        run_stim();
        checks++;
        if (obs_s[1] !== 16'h7FC0 || obs_s[2] !== 16'h0000) begin
            errors++;
            $display("FAIL cfg_collision: got %h %h, want 7fc0 (old sine) 0000 (new tri)", obs_s[1], obs_s[2]);
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("cfg[%0d] v=%0b s=%0d vx=%0d ox=%0d", i, obs_v[i], $signed(obs_s[i]), obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL cfg[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st;
        for (int i = 0; i < 200; i++) begin
            st = mk($urandom_range(0, 9) < 8, int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) == 0) begin
                st.we   = 1'b1;
                st.wosc = 2'($urandom);
                st.wave = 3'($urandom);
                st.pw   = 7'($urandom);
            end
            stim_q.push_back(st);
        end
        run_stim();
        for (int i = 0; i < exp_v.size(); i++) begin
            checks++;
            $display("b2b[%0d] v=%0b s=%0d vx=%0d ox=%0d", i, obs_v[i], $signed(obs_s[i]), obs_vx[i], obs_ox[i]);
            if (obs_v[i] !== exp_v[i] || obs_s[i] !== exp_s[i] || obs_vx[i] !== exp_vx[i] || obs_ox[i] !== exp_ox[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got v=%0b s=%h vx=%0d ox=%0d, want v=%0b s=%h vx=%0d ox=%0d", i,
                         obs_v[i], obs_s[i], obs_vx[i], obs_ox[i], exp_v[i], exp_s[i], exp_vx[i], exp_ox[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_midstream_reset();
        test_saw();
        test_pulse();
        test_sine();
        test_noise();
        test_cfg_collision();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
